// File: rtl/mem_pkg.sv
// Shared encodings for the data-RAM access controller: access sizes, grant
// identifiers, controller state and the request legality check.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT,
        ST_RESP,
        ST_ERR
    } state_t;

    // True when a request must be rejected without touching the RAM.
    function automatic logic access_error(input logic [1:0] size, input logic [1:0] addr_lsb);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lsb[0];
            SIZE_WORD: bad = |addr_lsb;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter between fetch (I) and load/store (D).
// On contention the requester that did not win last time gets the grant.
module mem_rr_arbiter
    import mem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic req_d,
    input  logic update,
    output logic grant_d
);

    logic last_grant_reg;

    // Reset leaves I as the last winner so the first tie goes to D.
    assign grant_d = req_d && (!req_i || (last_grant_reg == GRANT_I));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_reg <= GRANT_I;
        end else if (update) begin
            last_grant_reg <= grant_d ? GRANT_D : GRANT_I;
        end
    end

endmodule

// File: rtl/data_mem_access_ctrl.sv
// Shares the byte-addressed data RAM between instruction fetch and the
// load/store unit, generating a single Enable strobe with setup/hold around it.
module data_mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_sext,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              ram_enable,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [1:0]        ram_size,
    output logic [1:0]        ram_sext,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic              busy
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic              cap_d_reg;
    logic              cap_we_reg;
    logic [1:0]        cap_size_reg;
    logic              cap_sext_reg;
    logic [ADDR_W-1:0] cap_addr_reg;
    logic [31:0]       cap_wdata_reg;
    logic [31:0]       i_rdata_reg;
    logic [31:0]       d_rdata_reg;

    logic              grant_d;
    logic              arb_update;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic              sel_sext;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_bad;
    logic              load_rdata;

    mem_rr_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   (i_req),
        .req_d   (d_req),
        .update  (arb_update),
        .grant_d (grant_d)
    );

    // Fetches are forced to unsigned word reads regardless of the D-side inputs.
    always_comb begin
        arb_update = (state_reg == ST_IDLE) && (i_req || d_req);
        sel_we     = grant_d ? d_we : 1'b0;
        sel_size   = grant_d ? d_size : SIZE_WORD;
        sel_sext   = grant_d ? d_sext : 1'b0;
        sel_addr   = grant_d ? d_addr : i_addr;
        sel_wdata  = grant_d ? d_wdata : 32'd0;
        sel_bad    = access_error(sel_size, sel_addr[1:0]);
    end

    always_comb begin
        state_next = state_reg;
        load_rdata = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (arb_update) begin
                    state_next = sel_bad ? ST_ERR : ST_SETUP;
                end
            end
            ST_SETUP:  state_next = ST_STROBE;
            ST_STROBE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt_reg == CNT_LAST) begin
                    state_next = ST_RESP;
                    load_rdata = 1'b1;
                end
            end
            ST_RESP:  state_next = ST_IDLE;
            ST_ERR:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_reg  <= '0;
            cap_d_reg     <= GRANT_I;
            cap_we_reg    <= 1'b0;
            cap_size_reg  <= 2'b00;
            cap_sext_reg  <= 1'b0;
            cap_addr_reg  <= '0;
            cap_wdata_reg <= 32'd0;
            i_rdata_reg   <= 32'd0;
            d_rdata_reg   <= 32'd0;
        end else begin
            if (state_reg == ST_WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end else begin
                wait_cnt_reg <= '0;
            end

            // Fields are frozen at grant; later input changes do not reach the RAM.
            if (arb_update) begin
                cap_d_reg     <= grant_d;
                cap_we_reg    <= sel_we;
                cap_size_reg  <= sel_size;
                cap_sext_reg  <= sel_sext;
                cap_addr_reg  <= sel_addr;
                cap_wdata_reg <= sel_wdata;
                if (sel_bad) begin
                    if (grant_d) begin
                        d_rdata_reg <= 32'd0;
                    end else begin
                        i_rdata_reg <= 32'd0;
                    end
                end
            end

            if (load_rdata) begin
                if (cap_d_reg == GRANT_D) begin
                    d_rdata_reg <= cap_we_reg ? 32'd0 : ram_dout;
                end else begin
                    i_rdata_reg <= ram_dout;
                end
            end
        end
    end

    // Enable decodes straight from the state register so reset removes it at once.
    assign ram_enable = (state_reg == ST_STROBE);
    assign ram_rw     = cap_we_reg;
    assign ram_addr   = cap_addr_reg;
    assign ram_size   = cap_size_reg;
    assign ram_sext   = {1'b0, cap_sext_reg};
    assign ram_din    = cap_wdata_reg;

    assign i_ack   = ((state_reg == ST_RESP) || (state_reg == ST_ERR)) && (cap_d_reg == GRANT_I);
    assign d_ack   = ((state_reg == ST_RESP) || (state_reg == ST_ERR)) && (cap_d_reg == GRANT_D);
    assign i_err   = (state_reg == ST_ERR) && (cap_d_reg == GRANT_I);
    assign d_err   = (state_reg == ST_ERR) && (cap_d_reg == GRANT_D);
    assign i_rdata = i_rdata_reg;
    assign d_rdata = d_rdata_reg;
    assign busy    = (state_reg != ST_IDLE);

endmodule
